// File: rtl/booth_seq_multiplier.sv
// Sequential radix-2 Booth multiplier: one recoded digit per clock, 2N-bit signed product.
// Optional BOOTH_EARLY_EXIT_EN finishes as soon as all remaining Booth digits are zero.
module booth_seq_multiplier #(
  parameter int N = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N-1:0]     multiplicand,
  input  logic [N-1:0]     multiplier,
  output logic             busy,
  output logic             done,
  output logic [2*N-1:0]   product
);

  localparam int CW = $clog2(N + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]     r_state;
  logic [N:0]     r_a;
  logic [N-1:0]   r_q;
  logic           r_q_1;
  logic [CW-1:0]  r_count;
  logic [N-1:0]   r_m;
  logic [2*N-1:0] r_product;

  logic           w_h;
  logic           w_d;
  logic [N:0]     w_m_ext;
  logic [N:0]     w_sum;
  logic [N:0]     w_a_nxt;
  logic [N-1:0]   w_q_nxt;

  // Same recoding equations as the upstream Booth cell
  assign w_h     = r_q[0] ^ r_q_1;
  assign w_d     = r_q[0] & ~r_q_1;
  assign w_m_ext = {r_m[N-1], r_m};
  assign w_sum   = w_h ? (w_d ? (r_a - w_m_ext) : (r_a + w_m_ext)) : r_a;
  assign w_a_nxt = {w_sum[N], w_sum[N:1]};
  assign w_q_nxt = {w_sum[0], r_q[N-1:1]};

`ifdef BOOTH_EARLY_EXIT_EN
  logic [N-1:0]         w_mask;
  logic                 w_skip;
  logic signed [2*N:0]  w_aq_shr;

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < N; i++) begin
      w_mask[i] = (CW'(i) < r_count);
    end
  end

  // Remaining multiplier bits all equal q_1 means every remaining digit is zero
  assign w_skip   = (((r_q ^ {N{r_q_1}}) & w_mask) == '0);
  assign w_aq_shr = $signed({r_a, r_q}) >>> r_count;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_a       <= '0;
      r_q       <= '0;
      r_q_1     <= 1'b0;
      r_count   <= '0;
      r_m       <= '0;
      r_product <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= '0;
            r_q     <= multiplier;
            r_q_1   <= 1'b0;
            r_m     <= multiplicand;
            r_count <= CW'(N);
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
`ifdef BOOTH_EARLY_EXIT_EN
          if (w_skip) begin
            r_a       <= w_aq_shr[2*N:N];
            r_q       <= w_aq_shr[N-1:0];
            r_count   <= '0;
            r_product <= w_aq_shr[2*N-1:0];
            r_state   <= S_DONE;
          end else begin
`else
          begin
`endif
            r_a     <= w_a_nxt;
            r_q     <= w_q_nxt;
            r_q_1   <= r_q[0];
            r_count <= r_count - CW'(1);
            // Product is captured from the final shifted value on entry to DONE
            if (r_count == CW'(1)) begin
              r_product <= {w_a_nxt[N-1:0], w_q_nxt};
              r_state   <= S_DONE;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy    = (r_state == S_RUN);
  assign done    = (r_state == S_DONE);
  assign product = r_product;

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Scoreboard bench for booth_seq_multiplier: driver pushes expected products, monitor checks on done.
module tb_booth_seq_multiplier;
  localparam int N = 3;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [N-1:0]   multiplicand = '0;
  logic [N-1:0]   multiplier = '0;
  logic           busy;
  logic           done;
  logic [2*N-1:0] product;

  booth_seq_multiplier #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .busy(busy), .done(done), .product(product)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2*N-1:0] prod;
    int             e0;
    int             lat;
    int             a;
    int             b;
  } exp_t;

  exp_t           sb_q[$];
  int             tests = 0;
  int             failed = 0;
  int             edge_cnt = 0;
  int             n_start = 0;
  int             n_done = 0;
  logic [2*N-1:0] last_prod = '0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic void check(string name, longint act, longint exp_v);
    tests++;
    if (act != exp_v) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endfunction

  function automatic int sx(logic [N-1:0] v);
    return v[N-1] ? int'(v) - (1 << N) : int'(v);
  endfunction

  // Latency in edges counted from the accepting edge up to the one entering DONE, inclusive
  function automatic int exp_lat(logic [N-1:0] b);
    int j;
    bit cur;
    bit prv;
    j = N;
    for (int i = N - 1; i >= 0; i--) begin
      cur = b[i];
      prv = (i == 0) ? 1'b0 : b[i-1];
      if (cur != prv) break;
      j = i;
    end
`ifdef BOOTH_EARLY_EXIT_EN
    return ((j < N - 1) ? j : N - 1) + 2;
`else
    return N + 1;
`endif
  endfunction

  function automatic void push(logic [N-1:0] a, logic [N-1:0] b);
    exp_t e;
    e.prod = (2*N)'(sx(a) * sx(b));
    e.e0   = edge_cnt + 1;
    e.lat  = exp_lat(b);
    e.a    = sx(a);
    e.b    = sx(b);
    sb_q.push_back(e);
    n_start++;
  endfunction

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      check("busy_done_exclusive", longint'(busy & done), 0);
      if (done) begin
        n_done++;
        if (sb_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = sb_q.pop_front();
          check($sformatf("product %0d*%0d", e.a, e.b), longint'(product), longint'(e.prod));
          check($sformatf("latency %0d*%0d", e.a, e.b), longint'(edge_cnt - e.e0 + 1), longint'(e.lat));
          last_prod = e.prod;
        end
      end else if (!busy) begin
        check("product_hold", longint'(product), longint'(last_prod));
      end
    end
  end

  task automatic issue(logic [N-1:0] a, logic [N-1:0] b);
    int n;
    n = 0;
    @(negedge clk);
    while (busy || done) begin
      start        = 1'($urandom_range(0, 1));
      multiplicand = N'($urandom);
      multiplier   = N'($urandom);
      @(negedge clk);
      n++;
      if (n > 200) begin
        check("idle_timeout", 1, 0);
        return;
      end
    end
    start        = 1'b1;
    multiplicand = a;
    multiplier   = b;
    push(a, b);
    @(negedge clk);
    start        = 1'b0;
    multiplicand = N'($urandom);
    multiplier   = N'($urandom);
  endtask

  initial begin
    int prev_acc;
    int prev_lat;
    int k;
    int n;
    logic [N-1:0] ra;
    logic [N-1:0] rb;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_busy", longint'(busy), 0);
    check("reset_done", longint'(done), 0);
    check("reset_product", longint'(product), 0);

    // Reset during RUN discards the operation
    issue(3'sd3, 3'sd3);
    @(negedge clk);
    check("busy_before_reset", longint'(busy), 1);
    #2;
    rst = 1'b1;
    last_prod = '0;
    n_start -= sb_q.size();
    sb_q.delete();
    #1;
    check("midrun_reset_busy", longint'(busy), 0);
    check("midrun_reset_done", longint'(done), 0);
    check("midrun_reset_product", longint'(product), 0);
    @(negedge clk);
    rst = 1'b0;

    issue(3'b011, 3'b011);
    issue(3'b100, 3'b100);
    issue(3'b100, 3'b011);
    issue(3'b011, 3'b111);
    issue(3'b010, 3'b101);
    issue(3'b101, 3'b000);
    issue(3'b011, 3'b111);

    for (int a = 0; a < (1 << N); a++)
      for (int b = 0; b < (1 << N); b++)
        issue(N'(a), N'(b));

    for (int i = 0; i < 30; i++) begin
      ra = N'($urandom);
      rb = N'($urandom);
      issue(ra, rb);
    end

    // start held high: back-to-back operations
    @(negedge clk);
    n = 0;
    while ((busy || done) && n < 100) begin
      @(negedge clk);
      n++;
    end
    prev_acc = -1;
    prev_lat = 0;
    k = 0;
    n = 0;
    start = 1'b1;
    while (k < 6 && n < 200) begin
      multiplicand = N'($urandom);
      multiplier   = N'($urandom);
      if (!busy && !done) begin
        if (prev_acc >= 0)
          check("back_to_back_spacing", longint'(edge_cnt + 1 - prev_acc), longint'(prev_lat + 1));
        prev_acc = edge_cnt + 1;
        prev_lat = exp_lat(multiplier);
        push(multiplicand, multiplier);
        k++;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    if (k < 6) check("back_to_back_timeout", 1, 0);

    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", longint'(sb_q.size()), 0);
    repeat (3) @(negedge clk);
    check("done_count_vs_start_count", longint'(n_done), longint'(n_start));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
